// File: rtl/alu_pkg.sv
// Shared opcode constants and the result record for the alu_d1 sequencer slice.
package alu_pkg;

  localparam int ALU_W     = 32;
  localparam int ALU_TAG_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0]     data;
    logic [ALU_TAG_W-1:0] tag;
  } alu_res_t;

endpackage

// File: rtl/alu_d1.sv
// One-cycle-latency ALU: operands captured on the clock edge, result registered.
// No reset on purpose; its output is meaningless until it has been fed.
module alu_d1
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] s
);

  // Registered modulo-2^W result of the selected operation
  always_ff @(posedge clk) begin
    case (op)
      OP_ADD:  s <= a + b;
      OP_SUB:  s <= a - b;
      OP_AND:  s <= a & b;
      default: s <= a | b;
    endcase
  end

endmodule

// File: rtl/alu_res_fifo.sv
// In-order result FIFO. A push into a full FIFO is only honoured together with a pop.
module alu_res_fifo #(
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [TW-1:0] head_tag,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] data_mem [DEPTH];
  logic [TW-1:0] tag_mem  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr        = push && (!full || pop);
  assign rd        = pop && !empty;
  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];

  // Storage write at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (wr) begin
      data_mem[wr_ptr] <= push_data;
      tag_mem[wr_ptr]  <= push_tag;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= next_ptr(wr_ptr);
      if (rd) rd_ptr <= next_ptr(rd_ptr);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_d1_sequencer.sv
// Issue/retire stage around the handshake-free alu_d1: registered operands,
// a two-stage valid/tag pipeline matching the ALU latency, and a credit-gated result FIFO.
module alu_d1_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [W-1:0]     alu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             vld_p1, vld_p2;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic             accept, pop;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [CW:0]      credit;

  // Every in-flight op already owns a FIFO slot, so the FIFO can never overflow.
  // Only registered state feeds in_ready; a pop frees its slot one cycle later.
  assign credit   = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1} + {{CW{1'b0}}, vld_p2};
  assign in_ready = rst_n && !fifo_full && (credit < (CW + 1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = vld_p1 | vld_p2 | (fifo_count != '0);

  // Stage 0 -> 1: operand registers driving the ALU, held when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_ADD;
    end else if (accept) begin
      alu_a  <= in_a;
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  // Stage 1 -> 2: valid pipeline marks which ALU results belong to real ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Tag pipeline alongside the valids; only meaningful where the matching valid is set
  always_ff @(posedge clk) begin
    if (accept) tag_p1 <= in_tag;
    tag_p2 <= tag_p1;
  end

  // Stage 2: alu_s is captured only when vld_p2 marks it as a real result
  alu_res_fifo #(
    .DW    (W),
    .TW    (TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p2),
    .push_data (alu_s),
    .push_tag  (tag_p2),
    .pop       (pop),
    .head_data (out_data),
    .head_tag  (out_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_alu_d1_sequencer.sv
// Scoreboard bench for alu_d1_sequencer driving a real alu_d1.
module tb_alu_d1_sequencer;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     alu_a, alu_b, alu_s;
  logic [1:0]       alu_op;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  alu_res_t exp_q[$];
  int       acc_cyc_q[$];
  int       pop_cyc_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       pp_seen = 0;
  logic     prev_pp = 1'b0;
  logic [2:0] prev_cnt = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_d1_sequencer #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  alu_d1 #(.W(W)) u_alu (
    .clk(clk), .a(alu_a), .b(alu_b), .op(alu_op), .s(alu_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and watches FIFO occupancy
  always @(negedge clk) begin
    alu_res_t e;
    if (!rst_n) begin
      prev_pp = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          pop_cyc_q.push_back(cyc);
        end
      end
      if (u_dut.vld_p2) check("fifo_overflow", u_dut.fifo_full && !u_dut.pop, 1'b0);
      check("fifo_count_bound", u_dut.fifo_count > 3'(DEPTH), 1'b0);
      if (prev_pp) begin
        check("pushpop_count", u_dut.fifo_count, prev_cnt);
        pp_seen++;
      end
      prev_pp  = u_dut.vld_p2 && u_dut.pop;
      prev_cnt = u_dut.fifo_count;
    end
  end

  // Issue one op; called at a negedge, returns at the negedge after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag, input logic [W-1:0] exp_data);
    int n = 0;
    alu_res_t e;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_tag = tag;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 1'b1, 1'b0);
      in_valid = 1'b0;
      return;
    end
    e.data = exp_data;
    e.tag  = tag;
    exp_q.push_back(e);
    @(negedge clk);
    acc_cyc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, (exp_q.size() != 0) || busy, 1'b0);
  endtask

  // Issue a single add and check the exact 2-cycle latency and busy release
  task automatic latency_add(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TAG_W-1:0] tag, input logic [W-1:0] exp_data);
    send(a, b, OP_ADD, tag, exp_data);
    check("lat_after_e0", out_valid, 1'b0);
    @(negedge clk);
    check("lat_after_e1", out_valid, 1'b0);
    @(negedge clk);
    check("lat_after_e2", out_valid, 1'b1);
    check("lat_data", out_data, exp_data);
    check("lat_tag", out_tag, tag);
    @(negedge clk);
    check("busy_after_pop", busy, 1'b0);
  endtask

  initial begin
    int acc, idx, sent, n;
    alu_res_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD; in_tag = '0;
    out_ready = 1'b0;
    #1;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
    @(negedge clk);

    // Single add with latency
    out_ready = 1'b1;
    latency_add(32'd5, 32'd3, 4'd1, 32'd8);

    // Sub wrap, and, or
    send(32'd3, 32'd5, OP_SUB, 4'd2, 32'hFFFF_FFFE);
    wait_drain("drain_sub");
    send(32'h0000_F0F0, 32'h0000_0FF0, OP_AND, 4'd3, 32'h0000_00F0);
    wait_drain("drain_and");
    send(32'h0000_F0F0, 32'h0000_0FF0, OP_OR, 4'd4, 32'h0000_FFF0);
    wait_drain("drain_or");

    // Back-to-back: 8 ops, one per cycle, results one per cycle in order
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    pp_seen = 0;
    for (int i = 0; i < 8; i++)
      send(32'(i * 100 + 7), 32'(i * 3), OP_ADD, 4'(i), 32'(i * 103 + 7));
    wait_drain("drain_b2b");
    check("b2b_accept_count", acc_cyc_q.size(), 8);
    check("b2b_accept_span", acc_cyc_q[7] - acc_cyc_q[0], 7);
    check("b2b_result_count", pop_cyc_q.size(), 8);
    check("b2b_result_span", pop_cyc_q[7] - pop_cyc_q[0], 7);
    check("b2b_pushpop_seen", pp_seen > 0, 1'b1);

    // Backpressure: continuous in_valid, out_ready low
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_a = W'(idx) << 8; in_b = 32'hA500_0000 | W'(idx); in_op = OP_OR; in_tag = TAG_W'(idx + 8);
      if (in_ready) begin
        e.data = 32'hA500_0000 | (W'(idx) << 8) | W'(idx);
        e.tag  = TAG_W'(idx + 8);
        exp_q.push_back(e);
        acc++;
        idx++;
      end
      @(negedge clk);
    end
    check("bp_accepts", acc, 4);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_fifo_full", u_dut.fifo_count, 4);
    in_a = W'(idx) << 8; in_b = 32'hA500_0000 | W'(idx); in_tag = TAG_W'(idx + 8);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after_pop", in_ready, 1'b1);
    pp_seen = 0;
    sent = 0;
    n = 0;
    while (sent < 4 && n < 20) begin
      in_valid = 1'b1;
      in_a = W'(idx) << 8; in_b = 32'hA500_0000 | W'(idx); in_op = OP_OR; in_tag = TAG_W'(idx + 8);
      if (in_ready) begin
        e.data = 32'hA500_0000 | (W'(idx) << 8) | W'(idx);
        e.tag  = TAG_W'(idx + 8);
        exp_q.push_back(e);
        sent++;
        idx++;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("bp_refill_sent", sent, 4);
    wait_drain("drain_bp");
    check("bp_pushpop_seen", pp_seen > 0, 1'b1);

    // Reset mid-flight
    send(32'd11, 32'd22, OP_ADD, 4'hA, 32'd33);
    send(32'd40, 32'd1, OP_SUB, 4'hB, 32'd39);
    @(posedge clk);
    #2;
    check("mid_out_valid_pre", out_valid, 1'b1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_out_valid_async", out_valid, 1'b0);
    check("mid_busy_async", busy, 1'b0);
    check("mid_in_ready_async", in_ready, 1'b0);
    check("mid_alu_a_async", alu_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid_no_stale_result", out_valid, 1'b0);
    end
    latency_add(32'h7FFF_FFFF, 32'd1, 4'hC, 32'h8000_0000);
    wait_drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
